// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-ROM fetch arbiter.
// Port index 0 is the CPU fetch unit, index 1 the DMA reader.
package imem_arb_pkg;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned P_CORE    = 0;
  localparam int unsigned P_DMA     = 1;
  localparam int unsigned STREAK_W  = 8;

  typedef enum logic [1:0] {GNT_NONE, GNT_CORE, GNT_DMA} gnt_e;

  // One granted transfer: byte address, ROM word and address-check result.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } imem_xfer_s;

  // What a response slot captures on a fill.
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } imem_rsp_s;

  // Misaligned or beyond the last ROM word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/imem_rsp_slot.sv
// Single-entry response register for one requester: filled by a grant,
// drained by rsp_valid && rsp_ready; a drain and a refill may share a cycle.
module imem_rsp_slot
  import imem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fill,
  input  imem_rsp_s   fill_rsp,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (fill) begin
      rsp_valid <= 1'b1;
      // Faulting fetches still read the ROM; the word is discarded here.
      rsp_data  <= fill_rsp.err ? '0 : fill_rsp.data;
      rsp_err   <= fill_rsp.err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_err)));

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Two-port arbiter in front of a combinational instruction ROM (CORE vs DMA).
// Define IMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned DEPTH           = 4096,
  parameter int unsigned CORE_MAX_STREAK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic [31:0] core_req_addr,
  output logic        core_rsp_valid,
  input  logic        core_rsp_ready,
  output logic [31:0] core_rsp_data,
  output logic        core_rsp_err,
  input  logic        dma_req_valid,
  output logic        dma_req_ready,
  input  logic [31:0] dma_req_addr,
  output logic        dma_rsp_valid,
  input  logic        dma_rsp_ready,
  output logic [31:0] dma_rsp_data,
  output logic        dma_rsp_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_core_gnt,
  output logic [31:0] stat_dma_gnt,
  output logic [31:0] stat_conflict
`endif
);

  logic [NUM_PORTS-1:0]       req_valid, rsp_valid, rsp_ready, rsp_err, elig, fill;
  logic [NUM_PORTS-1:0][31:0] req_addr, rsp_data;
  logic [STREAK_W-1:0]        streak;
  logic                       streak_max, run;
  gnt_e                       gnt;
  imem_xfer_s                 win;
  imem_rsp_s                  win_rsp;

  assign req_valid = {dma_req_valid, core_req_valid};
  assign req_addr  = {dma_req_addr,  core_req_addr};
  assign rsp_ready = {dma_rsp_ready, core_rsp_ready};

  // Grants open one cycle after reset release so nothing is accepted in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign elig[p] = run && req_valid[p] && (!rsp_valid[p] || rsp_ready[p]);

    imem_rsp_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .fill      (fill[p]),
      .fill_rsp  (win_rsp),
      .rsp_ready (rsp_ready[p]),
      .rsp_valid (rsp_valid[p]),
      .rsp_data  (rsp_data[p]),
      .rsp_err   (rsp_err[p])
    );
  end

  assign streak_max = (streak == STREAK_W'(CORE_MAX_STREAK));

  always_comb begin
    gnt = GNT_NONE;
    if (elig[P_CORE] && !(elig[P_DMA] && streak_max)) gnt = GNT_CORE;
    else if (elig[P_DMA])                             gnt = GNT_DMA;
  end

  assign fill = {gnt == GNT_DMA, gnt == GNT_CORE};

  always_comb begin
    win.addr = '0;
    case (gnt)
      GNT_CORE: win.addr = req_addr[P_CORE];
      GNT_DMA:  win.addr = req_addr[P_DMA];
      default:  win.addr = '0;
    endcase
    win.data = mem_rdata;
    win.err  = addr_err(win.addr, DEPTH);
  end

  assign win_rsp  = '{data: win.data, err: win.err};
  assign mem_addr = win.addr;

  // Counts CORE wins while DMA waits; reaching the cap hands DMA the next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                streak <= '0;
    else if (gnt == GNT_DMA || !elig[P_DMA])   streak <= '0;
    else if (gnt == GNT_CORE && !streak_max)   streak <= streak + 1'b1;
  end

  assign core_req_ready = fill[P_CORE];
  assign dma_req_ready  = fill[P_DMA];
  assign core_rsp_valid = rsp_valid[P_CORE];
  assign core_rsp_data  = rsp_data[P_CORE];
  assign core_rsp_err   = rsp_err[P_CORE];
  assign dma_rsp_valid  = rsp_valid[P_DMA];
  assign dma_rsp_data   = rsp_data[P_DMA];
  assign dma_rsp_err    = rsp_err[P_DMA];

`ifdef IMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_core_gnt <= '0;
      stat_dma_gnt  <= '0;
      stat_conflict <= '0;
    end else begin
      stat_core_gnt <= sat_inc(stat_core_gnt, fill[P_CORE]);
      stat_dma_gnt  <= sat_inc(stat_dma_gnt,  fill[P_DMA]);
      stat_conflict <= sat_inc(stat_conflict, &elig);
    end
  end
`endif

  a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    !(core_req_ready && dma_req_ready));

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter: a per-cycle reference model plus
// literal checks of grant patterns, ROM words, error responses and counters.
module tb_imem_fetch_arbiter;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned MAXS  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req_valid, core_req_ready, core_rsp_valid, core_rsp_ready, core_rsp_err;
  logic        dma_req_valid, dma_req_ready, dma_rsp_valid, dma_rsp_ready, dma_rsp_err;
  logic [31:0] core_req_addr, core_rsp_data, dma_req_addr, dma_rsp_data, mem_addr, mem_rdata;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stat_core_gnt, stat_dma_gnt, stat_conflict;
`endif

  imem_fetch_arbiter #(.DEPTH(DEPTH), .CORE_MAX_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_addr(core_req_addr),
    .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
    .core_rsp_data(core_rsp_data), .core_rsp_err(core_rsp_err),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_addr(dma_req_addr),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_ready(dma_rsp_ready),
    .dma_rsp_data(dma_rsp_data), .dma_rsp_err(dma_rsp_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_STATS_EN
    , .stat_core_gnt(stat_core_gnt), .stat_dma_gnt(stat_dma_gnt), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  // ROM image: word w holds 0xC0DE_wwww, so ROM[4095] = 0xC0DE0FFF.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {16'hC0DE, a[17:2]};
  endfunction
  assign mem_rdata = rom(mem_addr);

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_s(input string nm, input string act, input string exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got '%s' want '%s'", nm, act, exp);
    end
  endtask

  // Requesters: hold the front address until it is accepted.
  logic [31:0] cq[$], dq[$];
  bit acc_c, acc_d;

  task automatic refresh();
    core_req_valid = (cq.size() > 0);
    core_req_addr  = (cq.size() > 0) ? cq[0] : 32'h0;
    dma_req_valid  = (dq.size() > 0);
    dma_req_addr   = (dq.size() > 0) ? dq[0] : 32'h0;
  endtask

  always @(posedge clk) begin
    #1;
    if (acc_c && cq.size() > 0) void'(cq.pop_front());
    if (acc_d && dq.size() > 0) void'(dq.pop_front());
    refresh();
  end

  // Reference model: slot contents, consecutive CORE wins over a waiting DMA, counters.
  bit          m_run;
  bit          m_v[2];
  logic [31:0] m_d[2];
  bit          m_e[2];
  int          m_streak;
  longint      m_sc, m_sd, m_sx;

  bit          log_en = 0;
  string       glog = "";
  logic [31:0] hq[$];
  logic [32:0] rlog[$];

  always @(negedge clk) begin : cmp
    bit ce, de, gc, gd, rdy;
    logic [31:0] ea, a;
    acc_c = core_req_ready;
    acc_d = dma_req_ready;
    if (!rst_n) begin
      m_run = 0; m_streak = 0; m_sc = 0; m_sd = 0; m_sx = 0;
      for (int p = 0; p < 2; p++) begin m_v[p] = 0; m_d[p] = 0; m_e[p] = 0; end
    end
    ce = rst_n && m_run && core_req_valid && (!m_v[0] || core_rsp_ready);
    de = rst_n && m_run && dma_req_valid  && (!m_v[1] || dma_rsp_ready);
    gd = de && (!ce || m_streak >= MAXS);
    gc = ce && !gd;
    ea = gc ? core_req_addr : (gd ? dma_req_addr : 32'h0);

    chk("core_req_ready", 32'(core_req_ready), 32'(gc));
    chk("dma_req_ready",  32'(dma_req_ready),  32'(gd));
    chk("mem_addr", mem_addr, ea);
    chk("core_rsp_valid", 32'(core_rsp_valid), 32'(m_v[0]));
    chk("dma_rsp_valid",  32'(dma_rsp_valid),  32'(m_v[1]));
    if (m_v[0] || !rst_n) begin
      chk("core_rsp_data", core_rsp_data, m_d[0]);
      chk("core_rsp_err",  32'(core_rsp_err), 32'(m_e[0]));
    end
    if (m_v[1] || !rst_n) begin
      chk("dma_rsp_data", dma_rsp_data, m_d[1]);
      chk("dma_rsp_err",  32'(dma_rsp_err), 32'(m_e[1]));
    end
`ifdef IMEM_ARB_STATS_EN
    chk("stat_core_gnt", stat_core_gnt, 32'(m_sc));
    chk("stat_dma_gnt",  stat_dma_gnt,  32'(m_sd));
    chk("stat_conflict", stat_conflict, 32'(m_sx));
`endif

    if (log_en) begin
      glog = {glog, core_req_ready ? "C" : (dma_req_ready ? "D" : "-")};
      if (core_rsp_valid) hq.push_back(core_rsp_data);
    end
    if (core_rsp_valid && core_rsp_ready) rlog.push_back({core_rsp_err, core_rsp_data});

    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        rdy = (p == 0) ? core_rsp_ready : dma_rsp_ready;
        if ((p == 0 && gc) || (p == 1 && gd)) begin
          a = (p == 0) ? core_req_addr : dma_req_addr;
          m_v[p] = 1;
          m_e[p] = bad_addr(a);
          m_d[p] = m_e[p] ? 32'h0 : rom(a);
        end else if (m_v[p] && rdy) begin
          m_v[p] = 0;
        end
      end
      if (gd || !de)                  m_streak = 0;
      else if (gc && m_streak < MAXS) m_streak++;
      if (gc) m_sc++;
      if (gd) m_sd++;
      if (ce && de) m_sx++;
      m_run = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int nc, nd;
    core_rsp_ready = 1; dma_rsp_ready = 1;
    refresh();

    // Reset held with both requesters valid, then release.
    for (int i = 0; i < 4; i++) begin cq.push_back(32'(i * 4)); dq.push_back(32'h100 + 32'(i * 4)); end
    refresh();
    step(3);
    rst_n = 1; glog = ""; log_en = 1;
    step(3);
    log_en = 0;
    chk_s("reset_release_gnts", glog, "-CC");
    step(12);

    // CORE alone, back to back.
    cq = '{32'h0, 32'h4, 32'h8}; refresh();
    rlog.delete(); glog = ""; log_en = 1;
    step(3);
    log_en = 0;
    step(3);
    chk_s("core_b2b_gnts", glog, "CCC");
    chk("core_b2b_cnt", 32'(rlog.size()), 32'd3);
    for (int i = 0; i < 3 && i < rlog.size(); i++)
      chk($sformatf("core_b2b_word%0d", i), rlog[i][31:0], 32'hC0DE0000 + 32'(i));

    // CORE response back-pressured for 5 cycles; DMA takes every slot.
    cq = '{32'h10, 32'h14};
    dq.delete();
    for (int i = 0; i < 8; i++) dq.push_back(32'h200 + 32'(i * 4));
    refresh();
    core_rsp_ready = 0; glog = ""; hq.delete(); log_en = 1;
    step(5);
    log_en = 0; core_rsp_ready = 1;
    chk_s("hold_gnts", glog, "CDDDD");
    chk("hold_cnt", 32'(hq.size()), 32'd4);
    for (int i = 0; i < hq.size(); i++) chk("hold_data", hq[i], 32'hC0DE0004);
    step(14);

    // Error responses and the last legal word.
    cq = '{32'h2, 32'h4000, 32'h3FFC}; refresh();
    rlog.delete();
    step(6);
    chk("err_cnt", 32'(rlog.size()), 32'd3);
    if (rlog.size() == 3) begin
      chk("err_misalign",  32'(rlog[0][32]), 32'd1);
      chk("err_misalign_d", rlog[0][31:0],   32'h0);
      chk("err_range",     32'(rlog[1][32]), 32'd1);
      chk("err_range_d",    rlog[1][31:0],   32'h0);
      chk("last_word_err", 32'(rlog[2][32]), 32'd0);
      chk("last_word_d",    rlog[2][31:0],   32'hC0DE0FFF);
    end

    // Both streaming for 100 grant cycles from a fresh reset.
    rst_n = 0;
    cq.delete(); dq.delete();
    for (int i = 0; i < 120; i++) begin cq.push_back(32'(i * 4)); dq.push_back(32'h800 + 32'(i * 4)); end
    refresh();
    step(2);
    rst_n = 1; glog = ""; log_en = 1;
    step(101);
    log_en = 0; cq.delete(); dq.delete(); refresh();
    nc = 0; nd = 0;
    for (int i = 0; i < glog.len(); i++) begin
      if (glog[i] == "C") nc++;
      if (glog[i] == "D") nd++;
    end
    chk_s("streak_pattern", glog.substr(1, 18), "CCCCCCCCDCCCCCCCCD");
    chk("stream_core_gnts", 32'(nc), 32'd89);
    chk("stream_dma_gnts",  32'(nd), 32'd11);
    step(2);
`ifdef IMEM_ARB_STATS_EN
    chk("stat_core_100", stat_core_gnt, 32'd89);
    chk("stat_dma_100",  stat_dma_gnt,  32'd11);
    chk("stat_conf_100", stat_conflict, 32'd100);
`endif

    // Reset asserted with both slots full.
    for (int i = 0; i < 10; i++) begin cq.push_back(32'h40 + 32'(i * 4)); dq.push_back(32'h900 + 32'(i * 4)); end
    refresh();
    step(4);
    rst_n = 0;
    #1;
    chk("midrst_core_valid", 32'(core_rsp_valid), 32'd0);
    chk("midrst_dma_valid",  32'(dma_rsp_valid),  32'd0);
`ifdef IMEM_ARB_STATS_EN
    chk("midrst_stat_core", stat_core_gnt, 32'd0);
    chk("midrst_stat_dma",  stat_dma_gnt,  32'd0);
    chk("midrst_stat_conf", stat_conflict, 32'd0);
`endif
    cq.delete(); dq.delete(); refresh();
    step(2);
    rst_n = 1;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
